// File: rtl/add_seq.sv
// add_seq: multi-cycle WORDS-byte adder/subtractor built around one 8-bit
// ripple slice. Bytes are processed least-significant first; the carry
// between bytes lives in a register. start/busy/done frame each operation.
//
// Handshake: start is sampled only while the block is not busy (IDLE or
// DONE); an accepted start latches a, b, sub and cin on that edge. busy is
// high for exactly WORDS cycles, then done pulses for one cycle with s, cout
// and ovf final. These outputs hold until the next accepted start. start
// during busy is ignored.
//
// Optional feature: define ADD_SEQ_OVF_EN to build signed-overflow detection
// on the top byte. Without it, ovf is tied to 0 and the port is kept.
module add_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [8*WORDS-1:0] a,
    input  logic [8*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [8*WORDS-1:0] s,
    output logic               cout,
    output logic               ovf,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index needs at least one bit even when WORDS is 1.
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [IW-1:0]      idx_q;
    logic               carry_q;
    logic               sub_q;
    logic [8*WORDS-1:0] a_q;
    logic [8*WORDS-1:0] b_q;

    logic               accept;
    logic               last;
    logic [7:0]         a_byte;
    logic [7:0]         b_byte;
    logic [8:0]         sum;

    assign accept = start && (state_q != RUN);
    assign last   = (idx_q == IW'(WORDS - 1));

    // One byte of the ripple slice: selected a byte plus conditionally inverted b byte plus carry.
    always_comb begin
        a_byte = a_q[8*idx_q +: 8];
        b_byte = b_q[8*idx_q +: 8] ^ {8{sub_q}};
        sum    = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
    end

    // Next-state logic: IDLE/DONE accept start, RUN lasts until the top byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture on accept, then one result byte and carry per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= cin;
            idx_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
        end else if (state_q == RUN) begin
            s[8*idx_q +: 8] <= sum[7:0];
            carry_q         <= sum[8];
            idx_q           <= idx_q + IW'(1);
            if (last) cout <= sum[8];
        end
    end

`ifdef ADD_SEQ_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into bit 7 of the current byte recovered from the sum bit.
    assign msb_cin = sum[7] ^ a_byte[7] ^ b_byte[7];

    // Signed overflow captured while the top byte is processed.
    always_ff @(posedge clk) begin
        if (rst)                         ovf_q <= 1'b0;
        else if (accept)                 ovf_q <= 1'b0;
        else if ((state_q == RUN) && last) ovf_q <= msb_cin ^ sum[8];
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_add_seq.sv
// Testbench for add_seq (WORDS=4): directed test-plan scenarios followed by
// randomized operations checked against an arithmetic reference model.
module tb_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;
`ifdef ADD_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           n_total = 0;
    int           n_pass  = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    // Reference: plain wide arithmetic; returns {ovf, cout, s}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic msub, input logic mcin);
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         sovf;
        bx   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, mcin};
        sovf = (ma[W-1] == bx[W-1]) && (full[W-1] != ma[W-1]);
        return {sovf, full};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; expected s is taken from the front of exp_q.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                          input logic tcin, input logic ec, input logic eo, input string tag);
        logic [W-1:0] es;
        int           lat;
        es    = exp_q.pop_front();
        a     = ta;
        b     = tb_v;
        sub   = tsub;
        cin   = tcin;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, W'(busy), W'(1));
        chk({tag, "_s_clear"}, s, '0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, W'(lat), W'(WORDS));
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, W'(cout), W'(ec));
        chk({tag, "_ovf"}, W'(ovf), W'(eo));
        chk({tag, "_busy_done"}, W'(busy), W'(0));
        tick();
        chk({tag, "_done_pulse"}, W'(done), W'(0));
        chk({tag, "_s_hold"}, s, es);
    endtask

    // Global time bound in case the DUT never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rc;
        int           edges;
        int           dcount;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_s", s, '0);
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));

        // Byte carry
        exp_q.push_back(32'h0000_0100);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, "bytecarry");
        // Full wrap
        exp_q.push_back(32'h0000_0000);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, "wrap");
        // Subtract 5 - 7
        exp_q.push_back(32'hFFFF_FFFE);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1'b0, "subtract");
        // Signed overflow
        exp_q.push_back(32'h8000_0000);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, OVF_ON, "sovf");

        // Start while busy is ignored, then back-to-back start through DONE
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 32'hAAAA_5555; b = 32'h0F0F_F0F0; sub = 1'b1; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_busy", W'(busy), W'(1));
        edges = 2;
        while (!done && edges < 12) begin
            tick();
            edges++;
        end
        chk("ignore_latency", W'(edges), W'(WORDS));
        chk("ignore_s", s, 32'h3333_3333);
        a = 32'h0000_0001; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", W'(busy), W'(1));
        chk("b2b_done", W'(done), W'(0));
        chk("b2b_s_clear", s, '0);
        edges = 0;
        while (!done && edges < 12) begin
            tick();
            edges++;
        end
        chk("b2b_latency", W'(edges), W'(WORDS));
        chk("b2b_s", s, 32'h0000_0002);
        tick();

        // Reset mid-operation after byte 1
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", W'(busy), W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_s", s, '0);
        chk("midrst_cout", W'(cout), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) dcount++;
        end
        chk("midrst_no_done", W'(dcount), W'(0));
        exp_q.push_back(32'h0000_0000);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, "afterrst");

        // rst and start on the same edge: rst wins
        a = 32'h0000_0005; b = 32'h0000_0005; rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rststart_busy", W'(busy), W'(0));
        tick();
        chk("rststart_busy2", W'(busy), W'(0));
        chk("rststart_s", s, '0);

        // Randomized operations against the reference model
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = {1'b0, {(W-1){1'b1}}};
            m = model(ra, rb, rs, rc);
            exp_q.push_back(m[W-1:0]);
            run_op(ra, rb, rs, rc, m[W], OVF_ON & m[W+1], "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
